dc_motor_ramp_ctrl: RTL and testbench
=====================================

// Module: dc_motor_ramp_ctrl
// PURPOSE
//  Sequences the four DC-motor PWM duty cycles (m0/m1 fwd/bwd) between the IO register file and the pwm instances.
//  Firmware issues per-motor {dir, target duty}; block ramps duty at a fixed slew, enforces brake + dead time on
//  reversal, honours emergency stop, never drives fwd and bwd of one motor non-zero together.
// PARAMETERS
//  CLK_FREQ         100000000  clk frequency, Hz
//  MOTOR_PWM_FREQ   500        pwm frequency; DCYCLE_MAX = CLK_FREQ/MOTOR_PWM_FREQ
//  DCYCLE_WL        18         duty width = $clog2(DCYCLE_MAX+1)
//  RAMP_TICK_HZ     1000       ramp update rate; tick period = CLK_FREQ/RAMP_TICK_HZ cycles
//  RAMP_STEP        1000       max duty change per tick
//  DEAD_TIME_MS     20         zero-output hold on reversal; DEAD_CYC = CLK_FREQ/1000*DEAD_TIME_MS
//  DISTANCE_WL      9          width of distance_cm
//  STOP_DISTANCE_CM 20         obstacle threshold
// PORTS
//  clk            in   1          system clock
//  reset          in   1          asynchronous, active-high
//  cmd_vld        in   1          command strobe
//  cmd_rdy        out  1          1 unless estop is high
//  cmd_motor      in   1          0=m0, 1=m1
//  cmd_dir        in   1          1=fwd, 0=bwd
//  cmd_dcycle     in   DCYCLE_WL  target duty
//  estop          in   1          level emergency stop
//  distance_vld   in   1          distance sample strobe
//  distance_cm    in   DISTANCE_WL measured distance; 0 = no echo
//  m0_fwd_dcycle, m0_bwd_dcycle, m1_fwd_dcycle, m1_bwd_dcycle  out DCYCLE_WL  registered duties to pwm
//  motor_busy     out  2          per motor: state != RUN or cur != tgt
//  obstacle_stop  out  1          sticky obstacle flag
// BEHAVIOUR
//  Reset: outputs, cur, tgt = 0; dir = fwd; state RUN; tick counter 0; obstacle_stop 0; cmd_rdy 0 while reset.
//    Mid-op reset forces outputs 0 immediately, without a clock edge.
//  Accept: cmd_vld & cmd_rdy. Target duty = min(cmd_dcycle, DCYCLE_MAX). Registered next cycle; a newer
//    command overwrites. First duty change occurs on the first tick after registration.
//  Tick: shared free-running counter; 1-cycle strobe every tick period. A tick coincident with acceptance uses the old target.
//  Per-motor FSM:
//    RUN:   on tick, cur moves toward tgt by <=RAMP_STEP, saturating, no overshoot and no wrap.
//           If tgt_dir != dir: cur==0 -> dir=tgt_dir in place; cur>0 -> BRAKE.
//    BRAKE: on tick, cur = max(cur-RAMP_STEP, 0); cur==0 -> DEAD, load counter DEAD_CYC.
//           If tgt_dir returns to dir -> RUN (ramp from cur).
//    DEAD:  cur held 0; counter decrements every cycle; at 0 -> dir=tgt_dir, RUN.
//           DEAD always completes, even if tgt_dir changes.
//  Outputs: fwd = dir ? cur : 0; bwd = dir ? 0 : cur. Registered.
//  estop high: both cur and tgt = 0 next cycle; state RUN; commands ignored. estop beats cmd in the same cycle.
// CONFIGURATION
//  ATROVER_OBSTACLE_STOP_EN defined:
//    - distance_vld with 0 < distance_cm < STOP_DISTANCE_CM sets obstacle_stop.
//    - Each motor with dir=fwd gets cur = tgt = 0 next cycle.
//    - While set, accepted fwd targets are forced to 0; bwd accepted normally.
//    - Cleared by distance_vld with distance_cm >= STOP_DISTANCE_CM. distance_cm == 0 is ignored.
//  Not defined: distance inputs unused; obstacle_stop tied 0.
// STRUCTURE
//  Package atrover_motor_pkg holds:
//    - motor_state_e {RUN, BRAKE, DEAD}
//    - motor_dir_e {BWD=0, FWD=1}
//    - DCYCLE_MAX / DEAD_CYC / tick-period constant functions
//  Sub-module dc_motor_ramp_channel: one FSM + cur/tgt/dir/dead counter, instantiated twice.
//  Top holds tick counter, command decode, estop/obstacle logic.
// TESTING (CLK_FREQ=1e6, MOTOR_PWM_FREQ=1000 -> DCYCLE_MAX=1000, RAMP_TICK_HZ=1e5 -> tick/10 cyc, RAMP_STEP=100, DEAD_TIME_MS=1 -> 1000 cyc)
//  1. cmd m0 fwd 500 -> m0_fwd 100,200..500 on 5 consecutive ticks; m0_bwd and m1 stay 0; motor_busy[0] drops after the 500 step.
//  2. cmd m1 bwd 1500 -> m1_bwd ramps to and holds 1000; m1_fwd stays 0.
//  3. m0 fwd at 300, cmd m0 bwd 200 -> fwd 200,100,0; then both 0 for 1000 cyc; then bwd 100,200. Never both non-zero.
//  4. Both motors at 400, estop=1 -> all outputs 0 next cycle; cmd_rdy=0; cmd during estop has no effect after release.
//  5. [ATROVER_OBSTACLE_STOP_EN] m1 fwd 600, distance 15 -> m1_fwd 0 next cycle, obstacle_stop=1;
//     fwd 300 cmd keeps 0; bwd 300 ramps; distance 50 clears flag; distance 0 has no effect.
//  6. Assert reset mid-ramp between clock edges -> outputs 0 immediately; after release fresh cmd ramps from 0.

Source files
------------

// File: rtl/dc_motor_ramp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atrover_motor_pkg
// Purpose  : Shared types and constant helpers for the DC-motor ramp
//            controller (state/direction encodings, derived cycle counts).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package atrover_motor_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BRAKE = 2'd1,
    DEAD  = 2'd2
  } motor_state_e;

  typedef enum logic {
    BWD = 1'b0,
    FWD = 1'b1
  } motor_dir_e;

  // Full-scale duty in clk cycles for one PWM period.
  function automatic int calc_dcycle_max(input int clk_freq, input int pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

  // Zero-output hold on reversal, in clk cycles.
  function automatic int calc_dead_cyc(input int clk_freq, input int dead_ms);
    return (clk_freq / 1000) * dead_ms;
  endfunction

  // Ramp tick period, in clk cycles.
  function automatic int calc_tick_period(input int clk_freq, input int tick_hz);
    return clk_freq / tick_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dc_motor_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dc_motor_ramp_ctrl_if
// Purpose  : Firmware command channel for the motor ramp controller.
// Signals  : cmd_vld    - command strobe (master -> slave)
//            cmd_rdy    - slave can accept (slave -> master)
//            cmd_motor  - 0 = motor 0, 1 = motor 1
//            cmd_dir    - 1 = forward, 0 = backward
//            cmd_dcycle - requested target duty
// Revision : 1.0 - initial release
// ============================================================================
interface dc_motor_ramp_ctrl_if #(
  parameter int DCYCLE_WL = 18
);
  logic                 cmd_vld;
  logic                 cmd_rdy;
  logic                 cmd_motor;
  logic                 cmd_dir;
  logic [DCYCLE_WL-1:0] cmd_dcycle;

  modport master (
    output cmd_vld, cmd_motor, cmd_dir, cmd_dcycle,
    input  cmd_rdy
  );

  modport slave (
    input  cmd_vld, cmd_motor, cmd_dir, cmd_dcycle,
    output cmd_rdy
  );
endinterface
`default_nettype wire

// File: rtl/dc_motor_ramp_channel.sv
`default_nettype none
// ============================================================================
// Module   : dc_motor_ramp_channel
// Purpose  : One motor: RUN/BRAKE/DEAD sequencer holding current duty,
//            target duty/direction, applied direction and dead-time counter.
//            Produces registered fwd/bwd duties; only one can be non-zero.
// Ports    : clk, reset      - clock, async active-high reset
//            tick            - 1-cycle ramp update strobe
//            estop           - zero cur/tgt, force RUN
//            obst_clr        - zero cur/tgt if currently driving forward
//            ld/ld_dir/ld_dcycle - new target (already clamped/forced)
//            fwd_dcycle/bwd_dcycle - registered duties
//            busy            - state != RUN or cur != tgt
// Revision : 1.0 - initial release
// ============================================================================
module dc_motor_ramp_channel
  import atrover_motor_pkg::*;
#(
  parameter int DCYCLE_WL = 18,
  parameter int RAMP_STEP = 1000,
  parameter int DEAD_CYC  = 2000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 estop,
  input  logic                 obst_clr,
  input  logic                 ld,
  input  logic                 ld_dir,
  input  logic [DCYCLE_WL-1:0] ld_dcycle,
  output logic [DCYCLE_WL-1:0] fwd_dcycle,
  output logic [DCYCLE_WL-1:0] bwd_dcycle,
  output logic                 busy
);

  localparam int                   DEAD_WL   = $clog2(DEAD_CYC + 1);
  localparam logic [DCYCLE_WL-1:0] STEP      = DCYCLE_WL'(RAMP_STEP);
  localparam logic [DEAD_WL-1:0]   DEAD_LOAD = DEAD_WL'(DEAD_CYC);

  motor_state_e         state_q, state_d;
  motor_dir_e           dir_q, dir_d;
  motor_dir_e           tgt_dir_q, tgt_dir_d;
  logic [DCYCLE_WL-1:0] cur_q, cur_d;
  logic [DCYCLE_WL-1:0] tgt_q, tgt_d;
  logic [DEAD_WL-1:0]   dead_q, dead_d;
  logic [DCYCLE_WL-1:0] fwd_q, fwd_d;
  logic [DCYCLE_WL-1:0] bwd_q, bwd_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      dir_q     <= FWD;
      tgt_dir_q <= FWD;
      cur_q     <= '0;
      tgt_q     <= '0;
      dead_q    <= '0;
      fwd_q     <= '0;
      bwd_q     <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      tgt_dir_q <= tgt_dir_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      dead_q    <= dead_d;
      fwd_q     <= fwd_d;
      bwd_q     <= bwd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    tgt_dir_d = tgt_dir_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    dead_d    = dead_q;

    unique case (state_q)
      RUN: begin
        // A direction change is handled before any ramping so the motor is
        // never pushed toward a new target in the old direction.
        if (tgt_dir_q != dir_q) begin
          if (cur_q == '0) dir_d = tgt_dir_q;
          else             state_d = BRAKE;
        end else if (tick) begin
          // Differences are compared rather than sums so nothing can wrap.
          if (cur_q < tgt_q)
            cur_d = ((tgt_q - cur_q) > STEP) ? cur_q + STEP : tgt_q;
          else if (cur_q > tgt_q)
            cur_d = ((cur_q - tgt_q) > STEP) ? cur_q - STEP : tgt_q;
        end
      end
      BRAKE: begin
        if (tgt_dir_q == dir_q) begin
          state_d = RUN;
        end else if (cur_q == '0) begin
          state_d = DEAD;
          dead_d  = DEAD_LOAD;
        end else if (tick) begin
          cur_d = (cur_q > STEP) ? cur_q - STEP : '0;
        end
      end
      DEAD: begin
        cur_d = '0;
        if (dead_q == '0) begin
          dir_d   = tgt_dir_q;
          state_d = RUN;
        end else begin
          dead_d = dead_q - DEAD_WL'(1);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Obstacle zeroing leaves the FSM alone so a reversal in progress still
    // gets its full dead time.
    if (obst_clr && (dir_q == FWD)) begin
      cur_d = '0;
      tgt_d = '0;
    end

    if (ld) begin
      tgt_d     = ld_dcycle;
      tgt_dir_d = motor_dir_e'(ld_dir);
    end

    if (estop) begin
      cur_d   = '0;
      tgt_d   = '0;
      state_d = RUN;
      dead_d  = '0;
    end

    // Outputs are built from next-state values so they track cur without
    // an extra cycle of lag; both derive from one dir bit, so they are
    // mutually exclusive.
    fwd_d = (dir_d == FWD) ? cur_d : '0;
    bwd_d = (dir_d == BWD) ? cur_d : '0;
  end

  assign fwd_dcycle = fwd_q;
  assign bwd_dcycle = bwd_q;
  assign busy       = (state_q != RUN) || (cur_q != tgt_q);

endmodule
`default_nettype wire

// File: rtl/dc_motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dc_motor_ramp_ctrl
// Purpose  : Sequences the four DC-motor PWM duties (m0/m1 fwd/bwd). Shared
//            ramp tick, command decode and clamp, emergency stop and optional
//            obstacle stop; two dc_motor_ramp_channel instances do the ramps.
// Config   : ATROVER_OBSTACLE_STOP_EN - enables distance-based obstacle stop;
//            when undefined distance inputs are ignored, obstacle_stop = 0.
// Ports    : clk, reset                 - clock, async active-high reset
//            cmd (slave modport)        - firmware command channel
//            estop                      - level emergency stop
//            distance_vld, distance_cm  - distance samples (0 = no echo)
//            m0/m1_fwd/bwd_dcycle       - registered duties to pwm
//            motor_busy[1:0]            - per-motor busy
//            obstacle_stop              - sticky obstacle flag
// Revision : 1.0 - initial release
// ============================================================================
module dc_motor_ramp_ctrl
  import atrover_motor_pkg::*;
#(
  parameter int CLK_FREQ         = 100000000,
  parameter int MOTOR_PWM_FREQ   = 500,
  parameter int DCYCLE_WL        = 18,
  parameter int RAMP_TICK_HZ     = 1000,
  parameter int RAMP_STEP        = 1000,
  parameter int DEAD_TIME_MS     = 20,
  parameter int DISTANCE_WL      = 9,
  parameter int STOP_DISTANCE_CM = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  dc_motor_ramp_ctrl_if.slave    cmd,
  input  logic                   estop,
  input  logic                   distance_vld,
  input  logic [DISTANCE_WL-1:0] distance_cm,
  output logic [DCYCLE_WL-1:0]   m0_fwd_dcycle,
  output logic [DCYCLE_WL-1:0]   m0_bwd_dcycle,
  output logic [DCYCLE_WL-1:0]   m1_fwd_dcycle,
  output logic [DCYCLE_WL-1:0]   m1_bwd_dcycle,
  output logic [1:0]             motor_busy,
  output logic                   obstacle_stop
);

  localparam int DCYCLE_MAX  = calc_dcycle_max(CLK_FREQ, MOTOR_PWM_FREQ);
  localparam int DEAD_CYC    = calc_dead_cyc(CLK_FREQ, DEAD_TIME_MS);
  localparam int TICK_PERIOD = calc_tick_period(CLK_FREQ, RAMP_TICK_HZ);
  localparam int TICK_WL     = $clog2(TICK_PERIOD + 1);

  localparam logic [DCYCLE_WL-1:0] DUTY_MAX = DCYCLE_WL'(DCYCLE_MAX);
  localparam logic [TICK_WL-1:0]   TICK_END = TICK_WL'(TICK_PERIOD - 1);

  // ---------------- ramp tick ----------------
  logic [TICK_WL-1:0] tick_cnt_q, tick_cnt_d;
  logic               tick;

  assign tick = (tick_cnt_q == TICK_END);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_WL'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  // ---------------- command decode ----------------
  logic                 accept;
  logic                 force_zero;
  logic                 obst_set;
  logic [DCYCLE_WL-1:0] tgt_clamped;
  logic [DCYCLE_WL-1:0] ld_dcycle;

  assign cmd.cmd_rdy  = ~estop & ~reset;
  assign accept       = cmd.cmd_vld & cmd.cmd_rdy;
  assign tgt_clamped  = (cmd.cmd_dcycle > DUTY_MAX) ? DUTY_MAX : cmd.cmd_dcycle;
  assign ld_dcycle    = force_zero ? '0 : tgt_clamped;

  // ---------------- obstacle stop ----------------
`ifdef ATROVER_OBSTACLE_STOP_EN
  logic obst_q, obst_d;
  logic obst_rel;

  // distance_cm == 0 means no echo and neither sets nor clears the flag.
  assign obst_set = distance_vld && (distance_cm != '0) &&
                    (distance_cm < DISTANCE_WL'(STOP_DISTANCE_CM));
  assign obst_rel = distance_vld && (distance_cm >= DISTANCE_WL'(STOP_DISTANCE_CM));

  always_comb begin
    obst_d = obst_q;
    if (obst_set)      obst_d = 1'b1;
    else if (obst_rel) obst_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) obst_q <= 1'b0;
    else       obst_q <= obst_d;
  end

  // Includes the setting cycle so a forward command racing the sample
  // cannot slip through.
  assign force_zero    = (obst_q | obst_set) & cmd.cmd_dir;
  assign obstacle_stop = obst_q;
`else
  logic unused_distance;

  assign unused_distance = (^{distance_vld, distance_cm}) ^ (STOP_DISTANCE_CM != 0);
  assign obst_set        = 1'b0;
  assign force_zero      = 1'b0;
  assign obstacle_stop   = 1'b0;
`endif

  // ---------------- channels ----------------
  logic [DCYCLE_WL-1:0] fwd_duty [2];
  logic [DCYCLE_WL-1:0] bwd_duty [2];

  for (genvar i = 0; i < 2; i++) begin : g_chan
    dc_motor_ramp_channel #(
      .DCYCLE_WL (DCYCLE_WL),
      .RAMP_STEP (RAMP_STEP),
      .DEAD_CYC  (DEAD_CYC)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .estop      (estop),
      .obst_clr   (obst_set),
      .ld         (accept && (cmd.cmd_motor == 1'(i))),
      .ld_dir     (cmd.cmd_dir),
      .ld_dcycle  (ld_dcycle),
      .fwd_dcycle (fwd_duty[i]),
      .bwd_dcycle (bwd_duty[i]),
      .busy       (motor_busy[i])
    );
  end

  assign m0_fwd_dcycle = fwd_duty[0];
  assign m0_bwd_dcycle = bwd_duty[0];
  assign m1_fwd_dcycle = fwd_duty[1];
  assign m1_bwd_dcycle = bwd_duty[1];

endmodule
`default_nettype wire

// File: tb/tb_dc_motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_motor_ramp_ctrl
// Purpose  : Directed self-checking bench for dc_motor_ramp_ctrl with
//            CLK_FREQ=1e6, PWM 1 kHz (max duty 1000), tick every 10 cycles,
//            step 100, dead time 1000 cycles. Obstacle scenario follows the
//            ATROVER_OBSTACLE_STOP_EN setting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_motor_ramp_ctrl;

  localparam int WL = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          estop = 1'b0;
  logic          distance_vld = 1'b0;
  logic [8:0]    distance_cm = '0;
  logic [WL-1:0] m0_fwd, m0_bwd, m1_fwd, m1_bwd;
  logic [1:0]    motor_busy;
  logic          obstacle_stop;

  int total = 0;
  int bad   = 0;

  dc_motor_ramp_ctrl_if #(.DCYCLE_WL(WL)) cmd_if ();

  dc_motor_ramp_ctrl #(
    .CLK_FREQ         (1000000),
    .MOTOR_PWM_FREQ   (1000),
    .DCYCLE_WL        (WL),
    .RAMP_TICK_HZ     (100000),
    .RAMP_STEP        (100),
    .DEAD_TIME_MS     (1),
    .DISTANCE_WL      (9),
    .STOP_DISTANCE_CM (20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd           (cmd_if),
    .estop         (estop),
    .distance_vld  (distance_vld),
    .distance_cm   (distance_cm),
    .m0_fwd_dcycle (m0_fwd),
    .m0_bwd_dcycle (m0_bwd),
    .m1_fwd_dcycle (m1_fwd),
    .m1_bwd_dcycle (m1_bwd),
    .motor_busy    (motor_busy),
    .obstacle_stop (obstacle_stop)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents one command for one edge; called just after a rising edge.
  task automatic send_cmd(input logic motor, input logic dir, input int dc);
    cmd_if.cmd_motor  = motor;
    cmd_if.cmd_dir    = dir;
    cmd_if.cmd_dcycle = WL'(dc);
    cmd_if.cmd_vld    = 1'b1;
    @(posedge clk); #1;
    cmd_if.cmd_vld    = 1'b0;
  endtask

  task automatic pulse_distance(input int cm);
    distance_cm  = 9'(cm);
    distance_vld = 1'b1;
    @(posedge clk); #1;
    distance_vld = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    total++;
    if ({m0_fwd, m0_bwd, m1_fwd, m1_bwd} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %0d/%0d/%0d/%0d required 0", m0_fwd, m0_bwd, m1_fwd, m1_bwd);
    end
    total++;
    if (cmd_if.cmd_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b required 0", cmd_if.cmd_rdy); end
    total++;
    if (motor_busy !== 2'b00) begin bad++; $display("FAIL reset_busy: got %b required 00", motor_busy); end
    total++;
    if (obstacle_stop !== 1'b0) begin bad++; $display("FAIL reset_obst: got %b required 0", obstacle_stop); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cmd_if.cmd_rdy !== 1'b1) begin bad++; $display("FAIL rdy_after_reset: got %b required 1", cmd_if.cmd_rdy); end
    total++;
    if ({m0_fwd, m0_bwd, m1_fwd, m1_bwd} !== '0) begin
      bad++; $display("FAIL idle_outputs: got %0d/%0d/%0d/%0d required 0", m0_fwd, m0_bwd, m1_fwd, m1_bwd);
    end
  endtask

  task automatic test_ramp_fwd();
    int   exp_v = 100;
    int   last  = -1;
    int   errs  = 0;
    logic exp_busy;
    send_cmd(1'b0, 1'b1, 500);
    for (int n = 0; n < 200 && exp_v <= 500; n++) begin
      @(posedge clk); #1;
      if (m0_bwd !== 0 || m1_fwd !== 0 || m1_bwd !== 0) errs++;
      if (m0_fwd === WL'(exp_v)) begin
        if (last >= 0) begin
          total++;
          if (n - last != 10) begin bad++; $display("FAIL ramp_interval: got %0d cycles required 10", n - last); end
        end
        exp_busy = (exp_v != 500);
        total++;
        if (motor_busy[0] !== exp_busy) begin
          bad++; $display("FAIL ramp_busy at %0d: got %b required %b", exp_v, motor_busy[0], exp_busy);
        end
        last  = n;
        exp_v = exp_v + 100;
      end else if (m0_fwd !== WL'(exp_v - 100)) begin
        errs++;
      end
    end
    total++;
    if (exp_v != 600) begin bad++; $display("FAIL ramp_reach: last step %0d required 500", exp_v - 100); end
    repeat (30) begin
      @(posedge clk); #1;
      if (m0_fwd !== 500 || m0_bwd !== 0 || m1_fwd !== 0 || m1_bwd !== 0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL ramp_others: got %0d bad samples required 0", errs); end
  endtask

  task automatic test_clamp();
    int exp_v = 100;
    int errs  = 0;
    send_cmd(1'b1, 1'b0, 1500);
    for (int n = 0; n < 300 && exp_v <= 1000; n++) begin
      @(posedge clk); #1;
      if (m1_fwd !== 0) errs++;
      if (m1_bwd === WL'(exp_v)) exp_v = exp_v + 100;
      else if (m1_bwd !== WL'(exp_v - 100)) errs++;
    end
    total++;
    if (exp_v != 1100) begin bad++; $display("FAIL clamp_reach: last step %0d required 1000", exp_v - 100); end
    repeat (40) begin
      @(posedge clk); #1;
      if (m1_bwd !== 1000 || m1_fwd !== 0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL clamp_hold: got %0d bad samples required 0", errs); end
    total++;
    if (motor_busy[1] !== 1'b0) begin bad++; $display("FAIL clamp_busy: got %b required 0", motor_busy[1]); end
  endtask

  task automatic test_reversal();
    int phase = 0;
    int exp_v = 200;
    int zeros = 0;
    int errs  = 0;
    int both  = 0;
    send_cmd(1'b0, 1'b1, 300);
    for (int n = 0; n < 100 && m0_fwd !== 300; n++) begin @(posedge clk); #1; end
    total++;
    if (m0_fwd !== 300) begin bad++; $display("FAIL rev_setup: got %0d required 300", m0_fwd); end
    send_cmd(1'b0, 1'b0, 200);
    for (int n = 0; n < 3000 && phase < 3; n++) begin
      @(posedge clk); #1;
      if (m0_fwd !== 0 && m0_bwd !== 0) both++;
      case (phase)
        0: begin
          if (m0_bwd !== 0) errs++;
          if (m0_fwd === WL'(exp_v)) begin
            if (exp_v == 0) begin phase = 1; zeros = 1; end
            else exp_v = exp_v - 100;
          end else if (m0_fwd !== WL'(exp_v + 100)) errs++;
        end
        1: begin
          if (m0_fwd === 0 && m0_bwd === 0) zeros++;
          else begin
            total++;
            if (zeros < 1000 || zeros > 1020) begin
              bad++; $display("FAIL rev_dead: got %0d zero cycles required 1000..1020", zeros);
            end
            total++;
            if (m0_bwd !== 100 || m0_fwd !== 0) begin
              bad++; $display("FAIL rev_first_bwd: got fwd %0d bwd %0d required 0/100", m0_fwd, m0_bwd);
            end
            phase = 2;
          end
        end
        default: begin
          if (m0_bwd === 200) phase = 3;
          else if (m0_bwd !== 100 || m0_fwd !== 0) errs++;
        end
      endcase
    end
    total++;
    if (phase != 3) begin bad++; $display("FAIL rev_complete: got phase %0d required 3", phase); end
    total++;
    if (errs != 0) begin bad++; $display("FAIL rev_steps: got %0d bad samples required 0", errs); end
    total++;
    if (both != 0) begin bad++; $display("FAIL rev_exclusive: got %0d overlap cycles required 0", both); end
  endtask

  task automatic test_estop();
    send_cmd(1'b0, 1'b1, 400);
    send_cmd(1'b1, 1'b0, 400);
    for (int n = 0; n < 3000 && !(m0_fwd === 400 && m1_bwd === 400); n++) begin @(posedge clk); #1; end
    total++;
    if (m0_fwd !== 400 || m1_bwd !== 400) begin
      bad++; $display("FAIL estop_setup: got m0_fwd %0d m1_bwd %0d required 400/400", m0_fwd, m1_bwd);
    end
    estop = 1'b1;
    #1;
    total++;
    if (cmd_if.cmd_rdy !== 1'b0) begin bad++; $display("FAIL estop_rdy: got %b required 0", cmd_if.cmd_rdy); end
    @(posedge clk); #1;
    total++;
    if ({m0_fwd, m0_bwd, m1_fwd, m1_bwd} !== '0) begin
      bad++; $display("FAIL estop_outputs: got %0d/%0d/%0d/%0d required 0", m0_fwd, m0_bwd, m1_fwd, m1_bwd);
    end
    total++;
    if (motor_busy !== 2'b00) begin bad++; $display("FAIL estop_busy: got %b required 00", motor_busy); end
    send_cmd(1'b0, 1'b1, 700);
    repeat (3) @(posedge clk);
    #1 estop = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if ({m0_fwd, m0_bwd, m1_fwd, m1_bwd} !== '0) begin
      bad++; $display("FAIL estop_ignored_cmd: got %0d/%0d/%0d/%0d required 0", m0_fwd, m0_bwd, m1_fwd, m1_bwd);
    end
    total++;
    if (cmd_if.cmd_rdy !== 1'b1) begin bad++; $display("FAIL estop_release_rdy: got %b required 1", cmd_if.cmd_rdy); end
  endtask

`ifdef ATROVER_OBSTACLE_STOP_EN
  task automatic test_obstacle();
    send_cmd(1'b1, 1'b1, 600);
    for (int n = 0; n < 200 && m1_fwd !== 600; n++) begin @(posedge clk); #1; end
    total++;
    if (m1_fwd !== 600) begin bad++; $display("FAIL obst_setup: got %0d required 600", m1_fwd); end
    pulse_distance(15);
    total++;
    if (m1_fwd !== 0) begin bad++; $display("FAIL obst_kill: got %0d required 0", m1_fwd); end
    total++;
    if (obstacle_stop !== 1'b1) begin bad++; $display("FAIL obst_set: got %b required 1", obstacle_stop); end
    send_cmd(1'b1, 1'b1, 300);
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (m1_fwd !== 0) begin bad++; $display("FAIL obst_fwd_blocked: got %0d required 0", m1_fwd); end
    send_cmd(1'b1, 1'b0, 300);
    for (int n = 0; n < 200 && m1_bwd !== 300; n++) begin @(posedge clk); #1; end
    total++;
    if (m1_bwd !== 300) begin bad++; $display("FAIL obst_bwd_ramp: got %0d required 300", m1_bwd); end
    pulse_distance(0);
    total++;
    if (obstacle_stop !== 1'b1) begin bad++; $display("FAIL obst_zero_keeps: got %b required 1", obstacle_stop); end
    pulse_distance(50);
    total++;
    if (obstacle_stop !== 1'b0) begin bad++; $display("FAIL obst_clear: got %b required 0", obstacle_stop); end
    pulse_distance(0);
    total++;
    if (obstacle_stop !== 1'b0) begin bad++; $display("FAIL obst_zero_noset: got %b required 0", obstacle_stop); end
    total++;
    if (m1_bwd !== 300) begin bad++; $display("FAIL obst_bwd_kept: got %0d required 300", m1_bwd); end
  endtask
`else
  task automatic test_obstacle();
    pulse_distance(15);
    total++;
    if (obstacle_stop !== 1'b0) begin bad++; $display("FAIL obst_disabled: got %b required 0", obstacle_stop); end
  endtask
`endif

  task automatic test_reset_mid();
    int exp_v = 100;
    send_cmd(1'b0, 1'b1, 800);
    for (int n = 0; n < 3000 && m0_fwd !== 300; n++) begin @(posedge clk); #1; end
    total++;
    if (m0_fwd !== 300) begin bad++; $display("FAIL midrst_setup: got %0d required 300", m0_fwd); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({m0_fwd, m0_bwd, m1_fwd, m1_bwd} !== '0) begin
      bad++; $display("FAIL midrst_async: got %0d/%0d/%0d/%0d required 0", m0_fwd, m0_bwd, m1_fwd, m1_bwd);
    end
    total++;
    if (cmd_if.cmd_rdy !== 1'b0) begin bad++; $display("FAIL midrst_rdy: got %b required 0", cmd_if.cmd_rdy); end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    send_cmd(1'b0, 1'b1, 200);
    total++;
    if (m0_fwd !== 0) begin bad++; $display("FAIL midrst_fresh_start: got %0d required 0", m0_fwd); end
    for (int n = 0; n < 100 && exp_v <= 200; n++) begin
      @(posedge clk); #1;
      if (m0_fwd === WL'(exp_v)) exp_v = exp_v + 100;
      else if (m0_fwd !== WL'(exp_v - 100)) begin
        total++; bad++;
        $display("FAIL midrst_ramp: got %0d required %0d or %0d", m0_fwd, exp_v - 100, exp_v);
        exp_v = 1000;
      end
    end
    total++;
    if (exp_v != 300) begin bad++; $display("FAIL midrst_reach: got step %0d required 200", exp_v - 100); end
  endtask

  initial begin
    cmd_if.cmd_vld    = 1'b0;
    cmd_if.cmd_motor  = 1'b0;
    cmd_if.cmd_dir    = 1'b1;
    cmd_if.cmd_dcycle = '0;
    test_reset();
    test_ramp_fwd();
    test_clamp();
    test_reversal();
    test_estop();
    test_obstacle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
